// File: rtl/mirfak_muldiv_pkg.sv
// Shared types and constants for the EX-stage mul/div sequencer and its result cache.
package mirfak_muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int TAG_W = 3 + 2 * XLEN;

  localparam int OP_IS_DIV = 2;
  localparam int OP_CMD_HI = 1;
  localparam int OP_CMD_LO = 0;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MUL   = 3'd1,
    ST_DIV   = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  function automatic logic [TAG_W-1:0] make_tag(input logic [2:0]      op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    return {op, a, b};
  endfunction

endpackage

// File: rtl/mirfak_muldiv_if.sv
// Bus between the mul/div sequencer and the shared iterative multiplier/divider.
interface mirfak_muldiv_if;
  import mirfak_muldiv_pkg::*;

  logic            mult_enable_o;
  logic            div_enable_o;
  logic [1:0]      unit_cmd_o;
  logic [XLEN-1:0] unit_op1_o;
  logic [XLEN-1:0] unit_op2_o;
  logic            mult_ack_i;
  logic [XLEN-1:0] mult_result_i;
  logic            div_ack_i;
  logic [XLEN-1:0] div_result_i;

  modport master (
    output mult_enable_o, div_enable_o, unit_cmd_o, unit_op1_o, unit_op2_o,
    input  mult_ack_i, mult_result_i, div_ack_i, div_result_i
  );

  modport slave (
    input  mult_enable_o, div_enable_o, unit_cmd_o, unit_op1_o, unit_op2_o,
    output mult_ack_i, mult_result_i, div_ack_i, div_result_i
  );

endinterface

// File: rtl/mirfak_muldiv_cache.sv
// Single-entry exact-repeat cache keyed on {op, a, b}; compiles to a constant miss when disabled.
module mirfak_muldiv_cache
  import mirfak_muldiv_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [TAG_W-1:0] lookup_tag_i,
  output logic             hit_o,
  output logic [XLEN-1:0]  data_o,
  input  logic             update_i,
  input  logic [TAG_W-1:0] update_tag_i,
  input  logic [XLEN-1:0]  update_data_i,
  input  logic             invalidate_i
);

  generate
    if (CACHE_EN) begin : g_entry
      logic             valid_q;
      logic [TAG_W-1:0] tag_q;
      logic [XLEN-1:0]  data_q;

      // Invalidate wins so a flushed sequence can never leave a stale entry behind.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          valid_q <= 1'b0;
          tag_q   <= '0;
          data_q  <= '0;
        end else if (invalidate_i) begin
          valid_q <= 1'b0;
        end else if (update_i) begin
          valid_q <= 1'b1;
          tag_q   <= update_tag_i;
          data_q  <= update_data_i;
        end
      end

      assign hit_o  = valid_q && (tag_q == lookup_tag_i);
      assign data_o = data_q;
    end else begin : g_none
      logic unused_cache;
      assign unused_cache = ^{clk_i, rst_ni, lookup_tag_i, update_i,
                              update_tag_i, update_data_i, invalidate_i};
      assign hit_o  = 1'b0;
      assign data_o = '0;
    end
  endgenerate

endmodule

// File: rtl/mirfak_muldiv_ctrl.sv
// Sequences the shared multiplier/divider for the EX stage: latch, enable until ack, hold result until consumed.
module mirfak_muldiv_ctrl
  import mirfak_muldiv_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   operand_a_i,
  input  logic [XLEN-1:0]   operand_b_i,
  input  logic              kill_i,
  input  logic              consume_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [XLEN-1:0]   result_o,
  mirfak_muldiv_if.master   unit_bus
);

  state_e          state_q, state_d;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [XLEN-1:0] result_q;

  logic            capture;
  logic            load_unit;
  logic            load_hit;
  logic            cache_upd;
  logic            cache_inv;
  logic            cache_hit;
  logic [XLEN-1:0] cache_data;
  logic [XLEN-1:0] unit_result;
  logic            mult_en;
  logic            div_en;
  logic            unit_ack;

  // DRAIN keeps whichever unit the flushed op started so it can finish cleanly.
  assign mult_en     = (state_q == ST_MUL) || ((state_q == ST_DRAIN) && !op_q[OP_IS_DIV]);
  assign div_en      = (state_q == ST_DIV) || ((state_q == ST_DRAIN) &&  op_q[OP_IS_DIV]);
  assign unit_ack    = (mult_en && unit_bus.mult_ack_i) || (div_en && unit_bus.div_ack_i);
  assign unit_result = op_q[OP_IS_DIV] ? unit_bus.div_result_i : unit_bus.mult_result_i;

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    load_unit = 1'b0;
    load_hit  = 1'b0;
    cache_upd = 1'b0;
    cache_inv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && !kill_i) begin
          capture = 1'b1;
          if (cache_hit) begin
            load_hit = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d  = op_i[OP_IS_DIV] ? ST_DIV : ST_MUL;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (unit_ack && !kill_i) begin
          load_unit = 1'b1;
          cache_upd = 1'b1;
          state_d   = ST_DONE;
        end else if (kill_i && unit_ack) begin
          state_d   = ST_IDLE;
        end else if (kill_i) begin
          cache_inv = 1'b1;
          state_d   = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (consume_i || kill_i) begin
          cache_inv = kill_i;
          state_d   = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (unit_ack) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (capture) begin
      op_q <= op_i;
      a_q  <= operand_a_i;
      b_q  <= operand_b_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_q <= '0;
    end else if (load_hit) begin
      result_q <= cache_data;
    end else if (load_unit) begin
      result_q <= unit_result;
    end
  end

  mirfak_muldiv_cache #(
    .CACHE_EN (CACHE_EN)
  ) u_cache (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .lookup_tag_i  (make_tag(op_i, operand_a_i, operand_b_i)),
    .hit_o         (cache_hit),
    .data_o        (cache_data),
    .update_i      (cache_upd),
    .update_tag_i  (make_tag(op_q, a_q, b_q)),
    .update_data_i (unit_result),
    .invalidate_i  (cache_inv)
  );

  assign busy_o   = req_valid_i && (state_q != ST_DONE);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;

  assign unit_bus.mult_enable_o = mult_en;
  assign unit_bus.div_enable_o  = div_en;
  assign unit_bus.unit_cmd_o    = op_q[OP_CMD_HI:OP_CMD_LO];
  assign unit_bus.unit_op1_o    = a_q;
  assign unit_bus.unit_op2_o    = b_q;

endmodule
